// File: rtl/bcd_display_scanner.sv
// Time-multiplexed BCD scan controller for an N-digit common-anode 7-segment display.
// Latency: an accepted load reaches the display at the next frame boundary (at most one frame + 1 cycle).
// Backpressure: load_ready drops while the one-entry shadow buffer holds a value not yet transferred.
module bcd_display_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter int LZ_BLANK     = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [4*NUM_DIGITS-1:0]       load_bcd,
    output logic [3:0]                    digit_bcd,
    output logic [NUM_DIGITS-1:0]         digit_en,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_done
);

    localparam int IW        = $clog2(NUM_DIGITS);
    localparam int CW        = $clog2(REFRESH_DIV);
    localparam int ON_CYCLES = REFRESH_DIV - BLANK_CYCLES;

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);

    typedef enum logic {
        S_BLANK = 1'b0,
        S_ON    = 1'b1
    } state_t;

    state_t                  state;
    logic [CW-1:0]           slot_cnt;
    logic [4*NUM_DIGITS-1:0] disp_reg;
    logic [4*NUM_DIGITS-1:0] shadow_reg;
    logic                    shadow_full;
    logic                    frame_end;

    logic [NUM_DIGITS-1:0]   lz_blank;
    logic                    zero_run;
    logic [3:0]              cur_nib;
    logic                    cur_blank;

    assign load_ready = !shadow_full;
    assign frame_end  = (state == S_ON) && (slot_cnt == ON_LAST) && (digit_idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_BLANK;
            slot_cnt    <= '0;
            digit_idx   <= '0;
            disp_reg    <= '0;
            shadow_reg  <= '0;
            shadow_full <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_BLANK: begin
                    if (slot_cnt == BLANK_LAST) begin
                        state    <= S_ON;
                        slot_cnt <= '0;
                    end else begin
                        slot_cnt <= slot_cnt + CW'(1);
                    end
                end
                S_ON: begin
                    if (slot_cnt == ON_LAST) begin
                        state    <= S_BLANK;
                        slot_cnt <= '0;
                        if (digit_idx == LAST_IDX) begin
                            digit_idx  <= '0;
                            frame_done <= 1'b1;
                        end else begin
                            digit_idx <= digit_idx + IW'(1);
                        end
                    end else begin
                        slot_cnt <= slot_cnt + CW'(1);
                    end
                end
                default: begin
                    state    <= S_BLANK;
                    slot_cnt <= '0;
                end
            endcase

            // Transfer needs a full shadow and a load needs an empty one, so the two never collide.
            if (frame_end && shadow_full) begin
                disp_reg    <= shadow_reg;
                shadow_full <= 1'b0;
            end else if (load_valid && !shadow_full) begin
                shadow_reg  <= load_bcd;
                shadow_full <= 1'b1;
            end
        end
    end

    // Walk from the most significant nibble down; a digit blanks while every nibble above it and itself is zero.
    always_comb begin
        zero_run = 1'b1;
        lz_blank = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (disp_reg[4*k +: 4] == 4'h0);
            if (k > 0 && LZ_BLANK != 0) begin
                lz_blank[k] = zero_run;
            end
        end
    end

    always_comb begin
        cur_nib   = 4'h0;
        cur_blank = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (digit_idx == IW'(k)) begin
                cur_nib   = disp_reg[4*k +: 4];
                cur_blank = lz_blank[k];
            end
        end
    end

    assign digit_bcd = cur_blank ? 4'hF : cur_nib;

    always_comb begin
        digit_en = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if ((state == S_ON) && !cur_blank && (digit_idx == IW'(k))) begin
                digit_en[k] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner: two instances (leading-zero blanking on and off) share one load stream.
module tb_bcd_display_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic [15:0] load_bcd = 16'h0000;

    logic        load_ready_a, load_ready_b;
    logic [3:0]  digit_bcd_a, digit_bcd_b;
    logic [3:0]  digit_en_a, digit_en_b;
    logic [1:0]  digit_idx_a, digit_idx_b;
    logic        frame_done_a, frame_done_b;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bcd_display_scanner #(
        .NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2), .LZ_BLANK(1)
    ) u_dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_ready(load_ready_a), .load_bcd(load_bcd),
        .digit_bcd(digit_bcd_a), .digit_en(digit_en_a), .digit_idx(digit_idx_a),
        .frame_done(frame_done_a)
    );

    bcd_display_scanner #(
        .NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2), .LZ_BLANK(0)
    ) u_dut_nolz (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_ready(load_ready_b), .load_bcd(load_bcd),
        .digit_bcd(digit_bcd_b), .digit_en(digit_en_b), .digit_idx(digit_idx_b),
        .frame_done(frame_done_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " rdy_a"}, load_ready_a, 1);
        chk({tag, " en_a"},  digit_en_a,   4'hF);
        chk({tag, " bcd_a"}, digit_bcd_a,  4'h0);
        chk({tag, " idx_a"}, digit_idx_a,  0);
        chk({tag, " fd_a"},  frame_done_a, 0);
        chk({tag, " rdy_b"}, load_ready_b, 1);
        chk({tag, " en_b"},  digit_en_b,   4'hF);
        chk({tag, " bcd_b"}, digit_bcd_b,  4'h0);
        chk({tag, " idx_b"}, digit_idx_b,  0);
        chk({tag, " fd_b"},  frame_done_b, 0);
    endtask

    // Called at cycle 0 of a frame; checks all 32 cycles and ends at cycle 0 of the next frame.
    // Nibble s of bcd_x / bit s of on_x give the expected code and lit-ness of slot s.
    task automatic check_frame(input string tag,
                               input logic [15:0] bcd_a, input logic [3:0] on_a,
                               input logic [15:0] bcd_b, input logic [3:0] on_b,
                               input logic fd0,
                               input logic ld0, input logic [15:0] val0,
                               input logic ld1, input logic [15:0] val1);
        int         s;
        logic [3:0] ea, eb;
        logic       erdy;
        for (int c = 0; c < 32; c++) begin
            s  = c / 8;
            ea = 4'hF;
            eb = 4'hF;
            if (c % 8 >= 2) begin
                if (on_a[s]) ea[s] = 1'b0;
                if (on_b[s]) eb[s] = 1'b0;
            end
            erdy = !(ld0 && c > 0);
            chk($sformatf("%s c%0d idx_a", tag, c), digit_idx_a, s);
            chk($sformatf("%s c%0d bcd_a", tag, c), digit_bcd_a, bcd_a[4*s +: 4]);
            chk($sformatf("%s c%0d en_a", tag, c),  digit_en_a,  ea);
            chk($sformatf("%s c%0d fd_a", tag, c),  frame_done_a, (c == 0) ? fd0 : 1'b0);
            chk($sformatf("%s c%0d rdy_a", tag, c), load_ready_a, erdy);
            chk($sformatf("%s c%0d idx_b", tag, c), digit_idx_b, s);
            chk($sformatf("%s c%0d bcd_b", tag, c), digit_bcd_b, bcd_b[4*s +: 4]);
            chk($sformatf("%s c%0d en_b", tag, c),  digit_en_b,  eb);
            chk($sformatf("%s c%0d fd_b", tag, c),  frame_done_b, (c == 0) ? fd0 : 1'b0);
            chk($sformatf("%s c%0d rdy_b", tag, c), load_ready_b, erdy);
            if (c == 0) begin
                load_valid = ld0;
                load_bcd   = val0;
            end else if (c == 1) begin
                load_valid = ld1;
                if (ld1) load_bcd = val1;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;

        check_frame("f0_reset", 16'hFFF0, 4'b0001, 16'h0000, 4'b1111, 1'b0, 1'b1, 16'h1234, 1'b0, 16'h0);
        check_frame("f1_1234",  16'h1234, 4'b1111, 16'h1234, 4'b1111, 1'b1, 1'b1, 16'h0050, 1'b0, 16'h0);
        check_frame("f2_0050",  16'hFF50, 4'b0011, 16'h0050, 4'b1111, 1'b1, 1'b1, 16'h1111, 1'b1, 16'h2222);
        check_frame("f3_1111",  16'h1111, 4'b1111, 16'h1111, 4'b1111, 1'b1, 1'b1, 16'h2222, 1'b0, 16'h0);
        check_frame("f4_2222",  16'h2222, 4'b1111, 16'h2222, 4'b1111, 1'b1, 1'b1, 16'h0A09, 1'b0, 16'h0);
        check_frame("f5_0a09",  16'hFA09, 4'b0111, 16'h0A09, 4'b1111, 1'b1, 1'b0, 16'h0,    1'b0, 16'h0);

        // Fill the shadow, then reset mid-ON of digit 2.
        load_valid = 1'b1;
        load_bcd   = 16'h7777;
        @(negedge clk);
        load_valid = 1'b0;
        chk("pend rdy_a", load_ready_a, 0);
        repeat (19) @(negedge clk);
        chk("midon idx_a", digit_idx_a, 2);
        chk("midon en_a",  digit_en_a,  4'b1011);
        chk("midon bcd_a", digit_bcd_a, 4'hA);
        chk("midon rdy_a", load_ready_a, 0);
        rst = 1'b1;
        @(negedge clk);
        chk_reset("midrst");
        rst = 1'b0;

        check_frame("r0", 16'hFFF0, 4'b0001, 16'h0000, 4'b1111, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        check_frame("r1", 16'hFFF0, 4'b0001, 16'h0000, 4'b1111, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
